temperature_calculator: RTL and testbench



---
 rtl/temperature_calculator.sv | 77 +++++++
 tb/tb_temperature_calculator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/temperature_calculator.sv
// Calibrated temperature: tempc = tc_base + tc_ref * adc_data.
// Two registered stages: the multiply stage, then the accumulate stage with a wrap flag.
module temperature_calculator #(
  parameter int BASE_W = 32,
  parameter int REF_W  = 8,
  parameter int ADC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BASE_W-1:0] tc_base,
  input  logic [REF_W-1:0]  tc_ref,
  input  logic [ADC_W-1:0]  adc_data,
  output logic [BASE_W-1:0] tempc,
  output logic              out_valid,
  output logic              tempc_ovf
);

  localparam int PROD_W = REF_W + ADC_W;

  // Handshake: valid-only, with no ready. Operands are taken on any edge where
  // in_valid=1. out_valid marks tempc/tempc_ovf for exactly one cycle. Every
  // result must be consumed in the cycle it is presented.

  logic [PROD_W-1:0] prod_q, prod_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              s1_valid_q, s1_valid_d;
  logic [BASE_W-1:0] tempc_q, tempc_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [BASE_W:0]   sum;

  always_comb begin
    prod_d     = prod_q;
    base_d     = base_q;
    s1_valid_d = in_valid;
    if (in_valid) begin
      prod_d = PROD_W'(tc_ref) * PROD_W'(adc_data);
      base_d = tc_base;
    end
  end

  // Add one guard bit so the carry out of the add becomes the wrap flag.
  always_comb begin
    sum         = {1'b0, base_q} + (BASE_W + 1)'(prod_q);
    tempc_d     = tempc_q;
    ovf_d       = ovf_q;
    out_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      tempc_d = sum[BASE_W-1:0];
      ovf_d   = sum[BASE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q      <= '0;
      base_q      <= '0;
      s1_valid_q  <= 1'b0;
      tempc_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      base_q      <= base_d;
      s1_valid_q  <= s1_valid_d;
      tempc_q     <= tempc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign tempc     = tempc_q;
  assign tempc_ovf = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_temperature_calculator.sv
// Bench for temperature_calculator. Each driven sample queues its {ovf, tempc};
// a negedge monitor pops one entry per out_valid cycle and checks it.
`timescale 1ns/1ps
module tb_temperature_calculator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] tc_base;
  logic [7:0]  tc_ref;
  logic [15:0] adc_data;
  logic [31:0] tempc;
  logic        out_valid;
  logic        tempc_ovf;

  logic [32:0] exp_q[$];
  int          compared;
  int          mismatched;
  int          valid_seen;

  temperature_calculator #(.BASE_W(32), .REF_W(8), .ADC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .tc_base   (tc_base),
    .tc_ref    (tc_ref),
    .adc_data  (adc_data),
    .tempc     (tempc),
    .out_valid (out_valid),
    .tempc_ovf (tempc_ovf)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] exp;
    if (!rst && out_valid) begin
      valid_seen++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_out_valid: got tempc=%h ovf=%b, required no output", tempc, tempc_ovf);
      end else begin
        exp = exp_q.pop_front();
        if ({tempc_ovf, tempc} !== exp) begin
          mismatched++;
          $display("FAIL result: got ovf=%b tempc=%h, required ovf=%b tempc=%h",
                   tempc_ovf, tempc, exp[32], exp[31:0]);
        end
      end
    end
  end

  function automatic logic [32:0] model(input logic [31:0] b, input logic [7:0] r, input logic [15:0] a);
    logic [32:0] p;
    p = 33'(r) * 33'(a);
    return 33'(b) + p;
  endfunction

  // Driver tasks
  task automatic send(input logic [31:0] b, input logic [7:0] r, input logic [15:0] a,
                      input logic [32:0] exp);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    tc_base  = b;
    tc_ref   = r;
    adc_data = a;
    exp_q.push_back(exp);
  endtask

  task automatic bubble();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tc_base  = 32'($urandom);
    tc_ref   = 8'($urandom);
    adc_data = 16'($urandom);
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tc_base = '0;
    tc_ref = '0;
    adc_data = '0;
    #12;
    compared++;
    if (tempc !== 32'h0 || out_valid !== 1'b0 || tempc_ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_values: got tempc=%h valid=%b ovf=%b, required 0/0/0", tempc, out_valid, tempc_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    valid_seen = 0;
    send(32'h8000_0001, 8'h81, 16'h0001, 33'h0_8000_0082);
    bubble();
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL nominal_latency_early: got out_valid=%b, required 0", out_valid);
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL nominal_latency: got out_valid=%b, required 1", out_valid);
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || valid_seen != 1) begin
      mismatched++;
      $display("FAIL nominal_pulse: got out_valid=%b pulses=%0d, required 0 and 1", out_valid, valid_seen);
    end
  endtask

  task automatic test_max_wrap();
    send(32'hFFFF_FFFF, 8'hFF, 16'hFFFF, 33'h1_00FE_FF00);
    bubble();
    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL max_wrap_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_operands();
    send(32'h1234_5678, 8'h00, 16'hABCD, 33'h0_1234_5678);
    send(32'hDEAD_BEEF, 8'h5A, 16'h0000, 33'h0_DEAD_BEEF);
    send(32'h0000_0000, 8'h00, 16'h0000, 33'h0_0000_0000);
    bubble();
    repeat (4) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL zero_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_streaming_bubble();
    logic pattern [4];
    pattern = '{1'b1, 1'b1, 1'b0, 1'b0};
    valid_seen = 0;
    send(32'h0,   8'h01, 16'h0001, 33'h0_0000_0001);
    send(32'd10,  8'h02, 16'h0003, 33'd16);
    send(32'h100, 8'h10, 16'h0010, 33'h0_0000_0200);
    bubble();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== pattern[i]) begin
        mismatched++;
        $display("FAIL stream_valid[%0d]: got %b, required %b", i, out_valid, pattern[i]);
      end
    end
    compared++;
    if (tempc !== 32'h200 || tempc_ovf !== 1'b0 || valid_seen != 3) begin
      mismatched++;
      $display("FAIL stream_hold: got tempc=%h ovf=%b pulses=%0d, required 00000200/0/3", tempc, tempc_ovf, valid_seen);
    end
  endtask

  task automatic test_async_reset();
    send(32'hFFFF_FFFF, 8'hFF, 16'hFFFF, 33'h1_00FE_FF00);
    bubble();
    @(posedge clk);
    #2;
    compared++;
    if (out_valid !== 1'b1 || tempc !== 32'h00FE_FF00 || tempc_ovf !== 1'b1) begin
      mismatched++;
      $display("FAIL async_pre: got valid=%b tempc=%h ovf=%b, required 1/00feff00/1", out_valid, tempc, tempc_ovf);
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    compared++;
    if (tempc !== 32'h0 || out_valid !== 1'b0 || tempc_ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: got tempc=%h valid=%b ovf=%b, required 0/0/0", tempc, out_valid, tempc_ovf);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_flight();
    valid_seen = 0;
    send(32'h0000_1000, 8'h22, 16'h0100, model(32'h0000_1000, 8'h22, 16'h0100));
    bubble();
    #2;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (valid_seen != 0 || tempc !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_mid_flight: got pulses=%0d tempc=%h, required 0/00000000", valid_seen, tempc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    logic [7:0]  r;
    logic [15:0] a;
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        b = 32'($urandom);
        r = 8'($urandom_range(0, 255));
        a = 16'($urandom_range(0, 65535));
        if (i % 9 == 0) b = 32'hFFFF_FF00 | b[7:0];
        send(b, r, a, model(b, r, a));
      end else begin
        bubble();
      end
    end
    bubble();
    repeat (4) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL back_to_back_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    valid_seen = 0;
    test_reset();
    test_nominal();
    test_max_wrap();
    test_zero_operands();
    test_streaming_bubble();
    test_async_reset();
    test_reset_mid_flight();
    test_nominal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
